// File: rtl/game_pkg.sv
// Shared definitions for the note lane game: state encodings, default code width, event pulse bundle.
// No logic; types and constants only.
// Not applicable: no handshakes live here.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_RUN   = 2'd1,
    GS_PAUSE = 2'd2,
    GS_DONE  = 2'd3
  } game_state_e;

  localparam int DEF_CODE_W = 8;

  // One-cycle scoring events, registered together so they share timing.
  typedef struct packed {
    logic hit;
    logic miss;
    logic wrong;
  } evt_t;

  localparam evt_t EVT_NONE  = 3'b000;
  localparam evt_t EVT_HIT   = 3'b100;
  localparam evt_t EVT_MISS  = 3'b010;
  localparam evt_t EVT_WRONG = 3'b001;

endpackage

// File: rtl/note_slot_queue.sv
// Compacting slot queue: slot 0 is the head; pop shifts everything down one slot, push appends.
// Latency: push/pop take effect at the next clock edge; read port and head are combinational from registers.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module note_slot_queue
  import game_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [CODE_W-1:0]          push_code_i,
  input  logic                       pop_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_slot_i,
  output logic [CODE_W-1:0]          rd_code_o,
  output logic                       rd_valid_o,
  output logic [CODE_W-1:0]          head_code_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CODE_W-1:0] slot_q [DEPTH];
  logic [CODE_W-1:0] slot_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wr_idx;

  // With a same-cycle pop the tail has already moved down one slot, so the write lands one lower.
  assign wr_idx = pop_i ? (count_q - 1'b1) : count_q;

  // Next slot contents: clear (optionally seeding slot 0), else shift on pop then write on push.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      if (push_i) slot_d[0] = push_code_i;
      count_d = push_i ? CNT_W'(1) : '0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < DEPTH-1; i++) slot_d[i] = slot_q[i+1];
        slot_d[DEPTH-1] = '0;
      end
      if (push_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) slot_d[i] = push_code_i;
        end
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Slot storage and occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  // Slots past the count are always zero, so validity is just an index compare.
  assign rd_valid_o  = (CNT_W'(rd_slot_i) < count_q);
  assign rd_code_o   = rd_valid_o ? slot_q[rd_slot_i] : '0;
  assign head_code_o = slot_q[0];
  assign count_o     = count_q;

endmodule

// File: rtl/note_lane_queue.sv
// Note lane game core: queue of expected scancodes, key matching, score/error counters, game FSM (combo bonus under NOTE_LANE_QUEUE_COMBO_EN).
// Latency: hit/miss/wrong pulse one cycle after the qualifying key/tick; read port is combinational.
// Backpressure: load_ready drops when the queue is full or the game is DONE; loads are dropped otherwise.
module note_lane_queue
  import game_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CODE_W  = DEF_CODE_W,
  parameter int SCORE_W = 10,
  parameter int MAX_ERR = 7,
  parameter int ERR_W   = 3
`ifdef NOTE_LANE_QUEUE_COMBO_EN
  ,
  parameter int COMBO_STEP = 4
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     scroll_tick,
  input  logic                     load,
  input  logic [CODE_W-1:0]        load_code,
  output logic                     load_ready,
  input  logic                     key_valid,
  input  logic [CODE_W-1:0]        key_code,
  input  logic [$clog2(DEPTH)-1:0] rd_slot,
  output logic [CODE_W-1:0]        rd_code,
  output logic                     rd_valid,
  output logic [CODE_W-1:0]        head_code,
  output logic                     head_valid,
  output logic                     hit,
  output logic                     miss,
  output logic                     wrong,
  output logic [SCORE_W-1:0]       score,
  output logic [ERR_W-1:0]         err_count,
  output logic [1:0]               state,
  output logic                     done
`ifdef NOTE_LANE_QUEUE_COMBO_EN
  ,
  output logic [SCORE_W-1:0]       combo
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SW1   = SCORE_W + 1;
  localparam int EW1   = ERR_W + 1;

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [ERR_W-1:0]   err_q, err_d;
  evt_t               evt_q, evt_d;

  logic [CNT_W-1:0]   count;
  logic               have, key_match, push, pop, clr;
  logic               play_en, hit_c, wrong_c, miss_c;
  logic [1:0]         score_inc;
  logic [SCORE_W:0]   score_sum;
  logic [ERR_W:0]     err_sum;
  logic [ERR_W-1:0]   err_sat;

  note_slot_queue #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_slots (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (clr),
    .push_i      (push),
    .push_code_i (load_code),
    .pop_i       (pop),
    .rd_slot_i   (rd_slot),
    .rd_code_o   (rd_code),
    .rd_valid_o  (rd_valid),
    .head_code_o (head_code),
    .count_o     (count)
  );

  assign have       = (count != '0);
  assign key_match  = (key_code == head_code);
  assign load_ready = (int'(count) < DEPTH) && (state_q != GS_DONE);
  assign push       = load & load_ready;

  // Play happens only in RUN, and not in a cycle that restarts, pauses or is about to end the game.
  assign play_en = (state_q == GS_RUN) && !start && !pause && (err_q < ERR_W'(MAX_ERR));
  assign hit_c   = play_en & key_valid & have & key_match;
  assign wrong_c = play_en & key_valid & have & ~key_match;
  assign miss_c  = play_en & scroll_tick & have & ~hit_c;
  assign pop     = hit_c | miss_c;
  assign clr     = start && (state_q != GS_IDLE);

  assign score_sum = {1'b0, score_q} + SW1'(score_inc);
  assign err_sum   = {1'b0, err_q} + EW1'(wrong_c) + EW1'(miss_c);
  assign err_sat   = (err_sum > EW1'(MAX_ERR)) ? ERR_W'(MAX_ERR) : err_sum[ERR_W-1:0];

`ifdef NOTE_LANE_QUEUE_COMBO_EN
  logic [SCORE_W-1:0] combo_q, combo_d;
  logic [SCORE_W:0]   combo_sum;

  // Bonus is judged on the streak before this hit is counted.
  assign score_inc = (int'(combo_q) >= COMBO_STEP) ? 2'd2 : 2'd1;
  assign combo_sum = {1'b0, combo_q} + SW1'(1);

  // Hit streak: grows on hits, cleared by any error or by a (re)start.
  always_comb begin
    combo_d = combo_q;
    if (start)                combo_d = '0;
    else if (wrong_c || miss_c) combo_d = '0;
    else if (hit_c)           combo_d = combo_sum[SCORE_W] ? combo_q : combo_sum[SCORE_W-1:0];
  end

  // Hit streak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) combo_q <= '0;
    else        combo_q <= combo_d;
  end

  assign combo = combo_q;
`else
  assign score_inc = 2'd1;
`endif

  // Game FSM plus score/error/event next state.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    err_d   = err_q;
    evt_d   = EVT_NONE;
    if (start) begin
      state_d = GS_RUN;
      score_d = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        GS_RUN: begin
          if (err_q >= ERR_W'(MAX_ERR)) state_d = GS_DONE;
          else if (pause)              state_d = GS_PAUSE;
          if (hit_c) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          err_d = err_sat;
          evt_d = (hit_c   ? EVT_HIT   : EVT_NONE)
                | (miss_c  ? EVT_MISS  : EVT_NONE)
                | (wrong_c ? EVT_WRONG : EVT_NONE);
        end
        GS_PAUSE: if (!pause) state_d = GS_RUN;
        default: ;
      endcase
    end
  end

  // State, counters and event pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GS_IDLE;
      score_q <= '0;
      err_q   <= '0;
      evt_q   <= EVT_NONE;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      err_q   <= err_d;
      evt_q   <= evt_d;
    end
  end

  assign hit        = evt_q.hit;
  assign miss       = evt_q.miss;
  assign wrong      = evt_q.wrong;
  assign score      = score_q;
  assign err_count  = err_q;
  assign state      = state_q;
  assign done       = (state_q == GS_DONE);
  assign head_valid = have;

endmodule

// File: tb/tb_note_lane_queue.sv
// Bench for note_lane_queue: directed scenarios then random play against a queue-based game model.
// Inputs change 1 time unit after the rising edge; outputs are compared at that same point.
// Covers both builds (combo checks only when NOTE_LANE_QUEUE_COMBO_EN is defined).
module tb_note_lane_queue;

  localparam int DEPTH      = 8;
  localparam int CODE_W     = 8;
  localparam int SCORE_W    = 10;
  localparam int MAX_ERR    = 7;
  localparam int ERR_W      = 3;
  localparam int COMBO_STEP = 4;
  localparam int IW         = $clog2(DEPTH);
  localparam int SMAX       = (1 << SCORE_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0, pause = 1'b0, scroll_tick = 1'b0, load = 1'b0, key_valid = 1'b0;
  logic [CODE_W-1:0] load_code = '0, key_code = '0;
  logic [IW-1:0]     rd_slot = '0;
  logic              load_ready, rd_valid, head_valid, hit, miss, wrong, done;
  logic [CODE_W-1:0] rd_code, head_code;
  logic [SCORE_W-1:0] score;
  logic [ERR_W-1:0]  err_count;
  logic [1:0]        state;
`ifdef NOTE_LANE_QUEUE_COMBO_EN
  logic [SCORE_W-1:0] combo;
`endif

  always #5 clk = ~clk;

  note_lane_queue dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .scroll_tick(scroll_tick),
    .load(load), .load_code(load_code), .load_ready(load_ready),
    .key_valid(key_valid), .key_code(key_code),
    .rd_slot(rd_slot), .rd_code(rd_code), .rd_valid(rd_valid),
    .head_code(head_code), .head_valid(head_valid),
    .hit(hit), .miss(miss), .wrong(wrong),
    .score(score), .err_count(err_count), .state(state), .done(done)
`ifdef NOTE_LANE_QUEUE_COMBO_EN
    , .combo(combo)
`endif
  );

  // Reference model: game rules applied to a plain queue.
  logic [CODE_W-1:0] mq[$];
  int m_state, m_score, m_err, m_combo;
  bit m_hit, m_miss, m_wrong;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_score = 0; m_err = 0; m_combo = 0;
    m_hit = 0; m_miss = 0; m_wrong = 0;
  endtask

  task automatic model_step(input bit st, input bit ps, input bit tk, input bit ld,
                            input logic [CODE_W-1:0] lc, input bit kv, input logic [CODE_W-1:0] kc);
    bit acc, h, w, mi;
    int inc;
    acc = ld && (mq.size() < DEPTH) && (m_state != 3);
    m_hit = 0; m_miss = 0; m_wrong = 0;
    if (st) begin
      if (m_state != 0) mq.delete();
      m_score = 0; m_err = 0; m_combo = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (m_err >= MAX_ERR) m_state = 3;
      else if (ps) m_state = 2;
      else if (mq.size() > 0) begin
        h  = kv && (kc == mq[0]);
        w  = kv && !h;
        mi = tk && !h;
        if (h || mi) void'(mq.pop_front());
        if (h) begin
          inc = 1;
`ifdef NOTE_LANE_QUEUE_COMBO_EN
          if (m_combo >= COMBO_STEP) inc = 2;
          m_combo = imin(m_combo + 1, SMAX);
`endif
          m_score = imin(m_score + inc, SMAX);
        end
        if (w || mi) begin
          m_err = imin(m_err + int'(w) + int'(mi), MAX_ERR);
          m_combo = 0;
        end
        m_hit = h; m_miss = mi; m_wrong = w;
      end
    end else if (m_state == 2 && !ps) begin
      m_state = 1;
    end
    if (acc) mq.push_back(lc);
  endtask

  task automatic check_all();
    int idx;
    idx = int'(rd_slot);
    chk("state", state, m_state);
    chk("done", done, (m_state == 3));
    chk("hit", hit, m_hit);
    chk("miss", miss, m_miss);
    chk("wrong", wrong, m_wrong);
    chk("score", score, m_score);
    chk("err_count", err_count, m_err);
    chk("head_valid", head_valid, (mq.size() > 0));
    chk("head_code", head_code, (mq.size() > 0) ? mq[0] : '0);
    chk("load_ready", load_ready, (mq.size() < DEPTH) && (m_state != 3));
    chk("rd_valid", rd_valid, (idx < mq.size()));
    chk("rd_code", rd_code, (idx < mq.size()) ? mq[idx] : '0);
`ifdef NOTE_LANE_QUEUE_COMBO_EN
    chk("combo", combo, m_combo);
`endif
  endtask

  // One clock of stimulus; rs<0 picks a random read slot.
  task automatic cyc(input bit st, input bit ps, input bit tk, input bit ld,
                     input logic [CODE_W-1:0] lc, input bit kv, input logic [CODE_W-1:0] kc, input int rs);
    start = st; pause = ps; scroll_tick = tk; load = ld; load_code = lc; key_valid = kv; key_code = kc;
    rd_slot = (rs < 0) ? IW'($urandom_range(0, DEPTH-1)) : IW'(rs);
    model_step(st, ps, tk, ld, lc, kv, kc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 8'h00, 0, 8'h00, -1);
  endtask

  bit ps_lvl;
  logic [CODE_W-1:0] rk;

  initial begin
    model_reset();
    #3;
    check_all();
    #9 reset = 1'b1;           // release between edges
    @(posedge clk); #1;
    check_all();

    // Preload three codes in IDLE, start, then a matching key.
    cyc(0, 0, 0, 1, 8'h1C, 0, 8'h00, -1);
    cyc(0, 0, 0, 1, 8'h1B, 0, 8'h00, -1);
    cyc(0, 0, 0, 1, 8'h23, 0, 8'h00, -1);
    cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, -1);
    cyc(0, 0, 0, 0, 8'h00, 1, 8'h1C, 1);
    chk("first_hit_score", score, 1);
    chk("first_hit_head", head_code, 8'h1B);
    // Wrong key, then a scroll tick miss.
    cyc(0, 0, 0, 0, 8'h00, 1, 8'h2B, -1);
    cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, -1);
    // Matching key and tick together: one pop, no miss.
    cyc(0, 0, 1, 0, 8'h00, 1, 8'h23, 0);

    // Fill to DEPTH, try one more, then pop+push at count 7.
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, CODE_W'(8'h30 + i), 0, 8'h00, -1);
    cyc(0, 0, 0, 1, 8'h77, 0, 8'h00, DEPTH-1);
    cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, -1);
    cyc(0, 0, 1, 1, 8'h66, 0, 8'h00, 6);
    chk("tail_slot6", rd_code, 8'h66);

    // Restart, then seven wrong keys to reach DONE.
    cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, -1);
    cyc(0, 0, 0, 1, 8'h55, 0, 8'h00, -1);
    for (int i = 0; i < MAX_ERR; i++) cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, -1);
    idle();
    chk("done_reached", done, 1'b1);
    cyc(0, 0, 1, 1, 8'h44, 1, 8'h55, 0);
    cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, -1);
    cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, 0);

    // Pause freezes play; loads still land.
    cyc(0, 0, 0, 1, 8'h41, 0, 8'h00, -1);
    cyc(0, 1, 0, 0, 8'h00, 1, 8'h41, -1);
    cyc(0, 1, 1, 1, 8'h42, 1, 8'h41, -1);
    cyc(0, 0, 0, 0, 8'h00, 0, 8'h00, -1);
    cyc(0, 0, 0, 0, 8'h00, 1, 8'h41, -1);

    // Six consecutive hits from a fresh game, then a wrong.
    cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, -1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, CODE_W'(8'h10 + i), 0, 8'h00, -1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 8'h00, 1, CODE_W'(8'h10 + i), -1);
`ifdef NOTE_LANE_QUEUE_COMBO_EN
    chk("combo_score", score, 8);
`else
    chk("plain_score", score, 6);
`endif
    cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, -1);

    // Random play.
    ps_lvl = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 6) ps_lvl = !ps_lvl;
      rk = ((mq.size() > 0) && ($urandom_range(0, 1) == 1)) ? mq[0] : CODE_W'($urandom_range(0, 255));
      cyc($urandom_range(0, 99) < 2, ps_lvl, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 40, CODE_W'($urandom_range(0, 255)),
          $urandom_range(0, 99) < 35, rk, -1);
    end

    // Reset in the middle of a game while a hit pulse is showing.
    cyc(1, 0, 0, 1, 8'h5A, 0, 8'h00, -1);
    cyc(0, 0, 0, 1, 8'h5B, 0, 8'h00, -1);
    cyc(0, 0, 0, 0, 8'h00, 1, 8'h5A, -1);
    chk("pre_reset_hit", hit, 1'b1);
    start = 0; pause = 0; scroll_tick = 0; load = 0; key_valid = 0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) reset = 1'b1;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_lane_queue.md
Name: note_lane_queue

Overview:
- Parametrised successor to the fixed 4-line scroll/error-check datapath.
- Holds a compacting queue of DEPTH expected key scancodes. Slot 0 is the head.
- On each scroll tick the head is popped. Keyboard scancodes are matched against the head, producing hit/miss/wrong events, a saturating score and an error count.
- Sits between the PS/2 scancode source, the frame-delay tick generator and the VGA text drawer, which reads slots through a random-access port.

Parameters:
- DEPTH, 8: number of queue slots; must be ≥2.
- CODE_W, 8: scancode width.
- SCORE_W, 10: score counter width.
- MAX_ERR, 7: error count that ends the game (the DONE threshold); must be ≥1.
- ERR_W, 3: error counter width; must satisfy 2^ERR_W > MAX_ERR.
- COMBO_STEP, 4: consecutive hits before the double-score bonus applies (COMBO_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins or restarts a game.
- pause  in  1  level; high freezes play.
- scroll_tick  in  1  one-cycle pulse from the frame delay counter.
- load  in  1  push request.
- load_code  in  CODE_W  scancode to push.
- load_ready  out  1  push accepted when load & load_ready.
- key_valid  in  1  one-cycle pulse for a new key.
- key_code  in  CODE_W  pressed scancode.
- rd_slot  in  $clog2(DEPTH)  display read index.
- rd_code  out  CODE_W  scancode in slot rd_slot (combinational).
- rd_valid  out  1  slot rd_slot occupied (combinational).
- head_code  out  CODE_W  slot 0 scancode.
- head_valid  out  1  count>0.
- hit  out  1  registered pulse.
- miss  out  1  registered pulse.
- wrong  out  1  registered pulse.
- score  out  SCORE_W  saturating hit score.
- err_count  out  ERR_W  misses plus wrongs, saturating at MAX_ERR.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- done  out  1  state==DONE.
- combo  out  SCORE_W  current hit streak (present only with COMBO_EN).

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; all slots empty; count=0.
  - score=0, err_count=0, combo=0.
  - hit, miss and wrong are 0.
- Queue representation:
  - Slots are always compacted. Slots 0..count-1 are valid; all others are cleared to code 0 and invalid.
- load_ready:
  - load_ready = (count<DEPTH) & (state!=DONE), computed from the registered count.
  - Loads are accepted in IDLE, RUN and PAUSE.
- Pop operation:
  - slot[i] ← slot[i+1]; slot[DEPTH-1] is cleared; count decrements.
- Push operation:
  - Writes to slot[count], or to slot[count-1] if a pop happens in the same cycle.
  - With a simultaneous pop, count is unchanged.
- RUN cycle priority, evaluated per cycle:
  1. key_valid with count>0 and key_code==head_code: pop; hit=1; score+1 (saturating).
  2. key_valid with count>0 and a mismatch: no pop; wrong=1; err_count+1.
  3. scroll_tick with count>0, when no hit occurred this cycle: pop; miss=1; err_count+1.
  - A hit and a scroll_tick in the same cycle produce a single pop and no miss.
  - A wrong and a scroll_tick in the same cycle produce a pop plus both wrong and miss; err_count increases by 2, saturating.
  - key_valid or scroll_tick with count==0 is ignored.
- Event latency:
  - hit, miss and wrong assert exactly one cycle after the qualifying inputs, for one cycle.
- State transitions:
  - IDLE → RUN on start: clears score, err_count and combo; keeps the preloaded queue.
  - RUN → PAUSE when pause=1. PAUSE → RUN when pause=0.
  - In PAUSE, key_valid and scroll_tick are ignored.
  - RUN → DONE in the cycle after err_count reaches MAX_ERR.
  - In DONE, everything is frozen except the read port.
  - DONE → RUN on start: clears the queue, score, err_count and combo.
  - start in RUN or PAUSE: same as the DONE restart, and goes to RUN.
- Reset mid-game returns to IDLE immediately; no pulses are emitted.

Optional Feature:
- Macro: NOTE_LANE_QUEUE_COMBO_EN.
- When defined:
  - combo counts consecutive hits (saturating) and resets to 0 on any miss or wrong.
  - A hit adds 2 to score if combo ≥ COMBO_STEP before the increment, otherwise 1.
  - The combo port exists.
- When undefined:
  - There is no combo port or register, and every hit adds 1.

Decomposition:
- Shared package game_pkg:
  - State encodings GS_IDLE/GS_RUN/GS_PAUSE/GS_DONE.
  - Default CODE_W.
  - Event-pulse bundle constants.
- Sub-module note_slot_queue:
  - Parametrised on DEPTH and CODE_W.
  - Implements the compacting push/pop storage, count and combinational read port.
- The top level holds the FSM, match logic and counters.

Test Plan:
- Preload 0x1C, 0x1B, 0x23, start, then key_valid 0x1C: hit=1 one cycle later; score=1; head_code=0x1B; count=2.
- RUN, head 0x1B, key_code 0x2B: wrong=1; err_count=1; head unchanged. Then a scroll_tick: miss=1; err_count=2; head=0x23.
- Same-cycle key 0x23 (matching) plus scroll_tick: single hit, no miss; count decrements by exactly 1.
- Fill to DEPTH=8: load_ready=0 and a further load is ignored. Pop plus load in the same cycle with count=7: new code lands in slot 6; count stays 7.
- Seven mismatches with MAX_ERR=7: err_count=7, then state=DONE; keys, ticks and loads are ignored; start → RUN with count=0 and score=0.
- COMBO_EN with COMBO_STEP=4: 6 consecutive hits → score=8 (hits 5 and 6 add 2). A following wrong resets combo to 0. Additionally, assert reset low mid-game: immediate IDLE with all outputs at their reset values.
